// File: rtl/sprite_scan_controller.sv
// Scans one SPRITE_W x SPRITE_H sprite as row-major ROM addresses and matching clipped VGA pixel coordinates.
// The pixel stage (x/y/plot/black) trails the address by one cycle to line up with synchronous ROM data.
module sprite_scan_controller #(
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 40,
    parameter int ADDR_W   = 11,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        xOrigin_i,
    input  logic [6:0]        yOrigin_i,
    input  logic              erase_i,
    output logic [ADDR_W-1:0] address_o,
    output logic [7:0]        x_o,
    output logic [6:0]        y_o,
    output logic              plot_o,
    output logic              black_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        xo_q, xo_d;
    logic [6:0]        yo_q, yo_d;
    logic              erase_q, erase_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic              plot_q, plot_d;
    logic              black_q, black_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // One extra bit so sprites hanging off the right/bottom edge clip instead of wrapping.
    logic [8:0] xs;
    logic [7:0] ys;
    assign xs = {1'b0, xo_q} + 9'(col_q);
    assign ys = {1'b0, yo_q} + 8'(row_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        erase_d = erase_q;
        x_d     = x_q;
        y_d     = y_q;
        plot_d  = 1'b0;
        black_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    xo_d    = xOrigin_i;
                    yo_d    = yOrigin_i;
                    erase_d = erase_i;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // (col_q,row_q) belong to the address issued last cycle; register its pixel now.
                x_d     = xs[7:0];
                y_d     = ys[6:0];
                plot_d  = (xs < 9'(SCREEN_W)) && (ys < 8'(SCREEN_H));
                black_d = erase_q;
                if (col_q == COL_LAST && row_q == ROW_LAST) begin
                    state_d = S_FLUSH;
                end else if (col_q == COL_LAST) begin
                    col_d  = '0;
                    row_d  = row_q + RW'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    col_d  = col_q + CW'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_FLUSH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            erase_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            plot_q  <= 1'b0;
            black_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            erase_q <= erase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            plot_q  <= plot_d;
            black_q <= black_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign address_o = addr_q;
    assign x_o       = x_q;
    assign y_o       = y_q;
    assign plot_o    = plot_q;
    assign black_o   = black_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_sprite_scan_controller.sv
// Bench for sprite_scan_controller: a 40x40 instance driven by full draws, and a 3x2 instance driven by a vector table.
module tb_sprite_scan_controller;

    localparam int W = 40;
    localparam int H = 40;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  xOrigin;
    logic [6:0]  yOrigin;
    logic        erase;
    logic [10:0] address;
    logic [7:0]  x;
    logic [6:0]  y;
    logic        plot, black, busy, done;

    logic        start_s;
    logic [2:0]  address_s;
    logic [7:0]  x_s;
    logic [6:0]  y_s;
    logic        plot_s, black_s, busy_s, done_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sprite_scan_controller dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .xOrigin_i(xOrigin), .yOrigin_i(yOrigin), .erase_i(erase),
        .address_o(address), .x_o(x), .y_o(y), .plot_o(plot),
        .black_o(black), .busy_o(busy), .done_o(done)
    );

    sprite_scan_controller #(.SPRITE_W(3), .SPRITE_H(2), .ADDR_W(3)) dut_s (
        .clk_i(clk), .reset_i(reset), .start_i(start_s),
        .xOrigin_i(8'd158), .yOrigin_i(7'd119), .erase_i(1'b0),
        .address_o(address_s), .x_o(x_s), .y_o(y_s), .plot_o(plot_s),
        .black_o(black_s), .busy_o(busy_s), .done_o(done_s)
    );

    typedef struct {
        logic start;
        int   addr;     // -1: not checked
        logic plot;
        logic chk_xy;
        int   x;
        int   y;
        logic busy;
        logic done;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_draw(input logic [7:0] x0, input logic [6:0] y0, input logic er,
                            input int exp_plots, input logic disturb);
        int plots;
        int pix;
        int ex, ey;
        int ep;
        xOrigin = x0;
        yOrigin = y0;
        erase   = er;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("e0_address", int'(address), 0);
        chk("e0_busy", int'(busy), 1);
        chk("e0_plot", int'(plot), 0);
        plots = 0;
        for (int k = 1; k <= N + 2; k++) begin
            if (disturb) begin
                start = (k == 100 || k == 801);
                if (k == 50) begin
                    erase   = ~er;
                    xOrigin = x0 + 8'd3;
                    yOrigin = y0 + 7'd2;
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (k < N)
                chk($sformatf("address@E%0d", k), int'(address), k);
            else if (k == N)
                chk("address_hold_flush", int'(address), N - 1);
            if (k <= N) begin
                pix = k - 1;
                ex  = int'(x0) + pix % W;
                ey  = int'(y0) + pix / W;
                ep  = (ex < 160 && ey < 120) ? 1 : 0;
                chk($sformatf("plot@pix%0d", pix), int'(plot), ep);
                if (ep == 1) begin
                    chk($sformatf("x@pix%0d", pix), int'(x), ex);
                    chk($sformatf("y@pix%0d", pix), int'(y), ey);
                end
                chk($sformatf("black@pix%0d", pix), int'(black), int'(er));
                chk($sformatf("busy@E%0d", k), int'(busy), 1);
                chk($sformatf("done@E%0d", k), int'(done), 0);
                plots += int'(plot);
            end else if (k == N + 1) begin
                chk("done_pulse", int'(done), 1);
                chk("busy_after_flush", int'(busy), 0);
                chk("plot_after_flush", int'(plot), 0);
                chk("black_after_flush", int'(black), 0);
            end else begin
                chk("done_one_cycle", int'(done), 0);
                chk("busy_idle", int'(busy), 0);
            end
        end
        chk("plot_count", plots, exp_plots);
        xOrigin = x0;
        yOrigin = y0;
        erase   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Small 3x2 sprite at (158,119), start held high: third column and second row are clipped.
        tbl[0]  = '{1'b1, 0,  1'b0, 1'b0, 0,   0,   1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1,  1'b1, 1'b1, 158, 119, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 2,  1'b1, 1'b1, 159, 119, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 3,  1'b0, 1'b1, 160, 119, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4,  1'b0, 1'b1, 158, 120, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 5,  1'b0, 1'b1, 159, 120, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 5,  1'b0, 1'b1, 160, 120, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, -1, 1'b0, 1'b0, 0,   0,   1'b0, 1'b1};
        tbl[8]  = '{1'b1, -1, 1'b0, 1'b0, 0,   0,   1'b0, 1'b0};
        tbl[9]  = '{1'b1, 0,  1'b0, 1'b0, 0,   0,   1'b1, 1'b0};
        tbl[10] = '{1'b1, 1,  1'b1, 1'b1, 158, 119, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 2,  1'b1, 1'b1, 159, 119, 1'b1, 1'b0};

        reset   = 1'b1;
        start   = 1'b0;
        start_s = 1'b0;
        xOrigin = 8'd0;
        yOrigin = 7'd0;
        erase   = 1'b0;

        // Reset applied before any rising clock edge.
        #3;
        chk("rst_address", int'(address), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_black", int'(black), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_small_address", int'(address_s), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            start_s = tbl[i].start;
            @(posedge clk);
            @(negedge clk);
            if (tbl[i].addr >= 0)
                chk($sformatf("small_address[%0d]", i), int'(address_s), tbl[i].addr);
            chk($sformatf("small_plot[%0d]", i), int'(plot_s), int'(tbl[i].plot));
            if (tbl[i].chk_xy) begin
                chk($sformatf("small_x[%0d]", i), int'(x_s), tbl[i].x);
                chk($sformatf("small_y[%0d]", i), int'(y_s), tbl[i].y);
            end
            chk($sformatf("small_black[%0d]", i), int'(black_s), 0);
            chk($sformatf("small_busy[%0d]", i), int'(busy_s), int'(tbl[i].busy));
            chk($sformatf("small_done[%0d]", i), int'(done_s), int'(tbl[i].done));
        end
        start_s = 1'b0;
        repeat (10) @(negedge clk);

        run_draw(8'd10, 7'd20, 1'b0, 1600, 1'b0);
        run_draw(8'd140, 7'd100, 1'b0, 400, 1'b0);
        run_draw(8'd10, 7'd20, 1'b1, 1600, 1'b1);

        // Abort a draw asynchronously when address reaches 500.
        xOrigin = 8'd10;
        yOrigin = 7'd20;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        chk("abort_address_500", int'(address), 500);
        chk("abort_busy_before", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_address", int'(address), 0);
        chk("abort_x", int'(x), 0);
        chk("abort_y", int'(y), 0);
        chk("abort_plot", int'(plot), 0);
        chk("abort_black", int'(black), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("abort_no_done[%0d]", k), int'(done), 0);
            chk($sformatf("abort_idle_busy[%0d]", k), int'(busy), 0);
        end
        run_draw(8'd10, 7'd20, 1'b0, 1600, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
